vram_loader: RTL and testbench
==============================

Name: vram_loader

Overview:
- Sequential DMA-style stage directly upstream of the video RAM write port; feeds it from the image ROM.
- Copies a programmable run of bytes from image ROM into video RAM, or clears a region with a constant.
- Drives the write port with a proper per-byte write strobe, paced by an allow input (e.g. blanking), with busy/done status for the top-level controller.

Parameters:
- ROM_AW, 12, image ROM address width (byte address)
- VRAM_AW, 11, video RAM address width
- DW, 8, data width of ROM and video RAM
- LEN_W, 12, width of the length field
- ROM_LAT, 1, image ROM read latency in clocks (1..3)

Ports:
- clk  in  1  single clock for the whole block; ROM, video RAM write port and loader share it
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = copy ROM->VRAM, 1 = fill with fill_value; sampled with start
- fill_value  in  DW  constant for fill mode; sampled with start
- src_base  in  ROM_AW  first ROM address; sampled with start
- dst_base  in  VRAM_AW  first VRAM address; sampled with start
- length  in  LEN_W  number of bytes to transfer; sampled with start
- allow  in  1  1 = may issue a new read this cycle
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- rom_ad  out  ROM_AW  image ROM address
- rom_data  in  DW  image ROM data, valid ROM_LAT cycles after address
- vram_ce  out  1  video RAM write strobe
- vram_ad  out  VRAM_AW  video RAM write address
- vram_data  out  DW  video RAM write data

Behaviour:
- Reset (async, rst low): state IDLE; busy=0, done=0, vram_ce=0, rom_ad=0, vram_ad=0, vram_data=0; in-flight pipeline cleared. Reset mid-transfer aborts immediately; vram_ce drops with rst, no done pulse.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 latches mode/fill_value/src_base/dst_base/length; remaining<=length; next state ISSUE if length!=0, else FINISH. start while not IDLE is ignored.
- ISSUE: each cycle with allow=1 and remaining!=0: present rom_ad=src_base+n (n = issue index), push {valid, dst_base+n} into a ROM_LAT-deep delay line, remaining-1. allow=0: no issue; rom_ad holds its value; the delay line still advances. When the last read is issued, next state DRAIN.
- Write timing: an element issued in cycle t produces vram_ce=1, vram_ad=dst_base+n, vram_data=rom_data (copy) or fill_value (fill) in cycle t+ROM_LAT. Fill mode uses identical timing. Throughput is 1 byte/clock while allow=1.
- In-flight reads always complete their writes, regardless of allow.
- DRAIN: wait until the delay line is empty, then go to FINISH.
- FINISH: done=1 for exactly one cycle; next state IDLE.
- busy=1 in every non-IDLE state: from the cycle after start through the done cycle inclusive.
- length=0: no ROM/VRAM activity; busy and done both high for one cycle, one cycle after start.
- Address arithmetic is modulo 2^ROM_AW and 2^VRAM_AW: wraps silently.
- length > 2^VRAM_AW is legal; later writes overwrite earlier ones after wrap.
- vram_ce=0 whenever no valid element leaves the delay line. vram_ad and vram_data are don't-care when vram_ce=0, but registered.

Decomposition:
- Shared package vram_pkg:
  - state enum (IDLE/ISSUE/DRAIN/FINISH)
  - mode constants MODE_COPY=0, MODE_FILL=1
  - default widths ROM_AW/VRAM_AW/DW/LEN_W
  - LCD window constants already used by the top (START_X, START_Y, 256x256 window)
- One sub-module, vram_wr_pipe: ROM_LAT-deep shift register carrying {valid, vram address}. It exposes an empty flag and the output valid/address.

Test Plan:
- Copy, ROM_LAT=1, allow=1, src_base=0x010, dst_base=0x000, length=4, ROM[0x010..0x013]=A1,B2,C3,D4 -> vram_ce high 4 consecutive cycles; writes (0x000,A1)(0x001,B2)(0x002,C3)(0x003,D4); first write 2 cycles after start; done 1 cycle after last write; busy low next cycle.
- Fill, fill_value=0x55, dst_base=0x7FE, length=4 -> writes 0x7FE,0x7FF,0x000,0x001 all data 0x55 (wrap check); rom_ad don't-care.
- Copy length=6 with allow low for 3 cycles after the 2nd issue -> exactly 6 writes, correct addresses/data in order; gap of 3 cycles in vram_ce; exactly one done pulse.
- length=0 start -> vram_ce never high; busy=1 and done=1 for exactly one cycle, one cycle after start.
- start pulsed again while busy (different src/dst) -> ignored; original transfer completes unchanged.
- rst low during 3rd write of a length=8 copy -> vram_ce/busy/done 0 immediately; after release state IDLE; a new start runs a full, correct transfer.
- ROM_LAT=2 rerun of the first scenario -> same writes, first write 3 cycles after start.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the video RAM loader.
package vram_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Transfer modes, sampled together with start.
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Default widths for the image ROM / video RAM path.
  localparam int DEF_ROM_AW  = 12;
  localparam int DEF_VRAM_AW = 11;
  localparam int DEF_DW      = 8;
  localparam int DEF_LEN_W   = 12;

  // LCD window placement used by the display top level.
  localparam int LCD_START_X = 32;
  localparam int LCD_START_Y = 8;
  localparam int LCD_WIN_W   = 256;
  localparam int LCD_WIN_H   = 256;

endpackage

// File: rtl/vram_wr_pipe.sv
// Delay line that carries {valid, vram address} alongside the image ROM
// read latency, so each write address meets its ROM data.
module vram_wr_pipe #(
  parameter int AW  = 11,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_addr_i,
  output logic          out_valid_o,
  output logic [AW-1:0] out_addr_o,
  output logic          empty_o
);

  logic [LAT-1:0] valid_q;
  logic [AW-1:0]  addr_q [LAT];

  // Shift every stage each cycle; bubbles enter when nothing is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      addr_q[0]  <= in_addr_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  // Empty means nothing is in flight behind the stage being written now,
  // so the line is fully drained at the end of this cycle.
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      if (valid_q[i]) empty_o = 1'b0;
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_addr_o  = addr_q[LAT-1];

endmodule

// File: rtl/vram_loader.sv
// Copies a run of bytes from image ROM into video RAM, or fills a VRAM
// region with a constant, paced by allow. Valid/ready style pacing: a read
// is issued only in a cycle where allow=1 and bytes remain; once issued, an
// element always reaches the write port ROM_LAT cycles later.
module vram_loader
  import vram_pkg::*;
#(
  parameter int ROM_AW  = DEF_ROM_AW,
  parameter int VRAM_AW = DEF_VRAM_AW,
  parameter int DW      = DEF_DW,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [DW-1:0]      fill_value,
  input  logic [ROM_AW-1:0]  src_base,
  input  logic [VRAM_AW-1:0] dst_base,
  input  logic [LEN_W-1:0]   length,
  input  logic               allow,
  output logic               busy,
  output logic               done,
  output logic [ROM_AW-1:0]  rom_ad,
  input  logic [DW-1:0]      rom_data,
  output logic               vram_ce,
  output logic [VRAM_AW-1:0] vram_ad,
  output logic [DW-1:0]      vram_data,
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [DW-1:0]      fill_q, fill_d;
  logic [ROM_AW-1:0]  src_q, src_d;       // next ROM address to issue
  logic [VRAM_AW-1:0] dst_q, dst_d;       // next VRAM address to issue
  logic [LEN_W-1:0]   rem_q, rem_d;       // bytes not yet issued
  logic [ROM_AW-1:0]  rom_ad_q, rom_ad_d; // last issued ROM address
  logic               issue;
  logic               pipe_valid;
  logic [VRAM_AW-1:0] pipe_addr;
  logic               pipe_empty;

  // State and transfer-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_COPY;
      fill_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      rom_ad_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      rom_ad_q <= rom_ad_d;
    end
  end

  // Next-state logic: latch the request, issue one byte per allowed cycle,
  // drain the delay line, then pulse done.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    rom_ad_d = rom_ad_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          fill_d  = fill_value;
          src_d   = src_base;
          dst_d   = dst_base;
          rem_d   = length;
          state_d = (length != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        if (allow && (rem_q != '0)) begin
          issue    = 1'b1;
          rom_ad_d = src_q;
          src_d    = src_q + 1'b1;
          dst_d    = dst_q + 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  vram_wr_pipe #(
    .AW  (VRAM_AW),
    .LAT (ROM_LAT)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (issue),
    .in_addr_i   (dst_q),
    .out_valid_o (pipe_valid),
    .out_addr_o  (pipe_addr),
    .empty_o     (pipe_empty)
  );

  // The ROM sees the new address in the issue cycle; otherwise it holds.
  assign rom_ad    = issue ? src_q : rom_ad_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign vram_ce   = pipe_valid;
  assign vram_ad   = pipe_addr;
  // ROM data arrives in the write cycle itself, so data is selected here
  // and forced to zero whenever no write is presented.
  assign vram_data = !pipe_valid          ? '0 :
                     (mode_q == MODE_FILL) ? fill_q : rom_data;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_loader.sv
// Self-checking bench for vram_loader: a ROM_LAT=1 and a ROM_LAT=2
// instance share stimulus; writes of the selected instance are collected
// and compared against a transfer-level reference model.
module tb_vram_loader;
  import vram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT stimulus ----------------
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  fill_value = '0;
  logic [11:0] src_base = '0;
  logic [10:0] dst_base = '0;
  logic [11:0] length = '0;
  logic        allow = 1'b1;

  logic        busy1, done1, ce1, busy2, done2, ce2;
  logic [11:0] rom_ad1, rom_ad2;
  logic [7:0]  rom_data1, rom_data2;
  logic [10:0] vad1, vad2;
  logic [7:0]  vdat1, vdat2;
  state_e      st1, st2;

  vram_loader #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fill_value(fill_value),
    .src_base(src_base), .dst_base(dst_base), .length(length), .allow(allow),
    .busy(busy1), .done(done1), .rom_ad(rom_ad1), .rom_data(rom_data1),
    .vram_ce(ce1), .vram_ad(vad1), .vram_data(vdat1), .dbg_state(st1)
  );

  vram_loader #(.ROM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fill_value(fill_value),
    .src_base(src_base), .dst_base(dst_base), .length(length), .allow(allow),
    .busy(busy2), .done(done2), .rom_ad(rom_ad2), .rom_data(rom_data2),
    .vram_ce(ce2), .vram_ad(vad2), .vram_data(vdat2), .dbg_state(st2)
  );

  // ---------------- image ROM model ----------------
  logic [7:0] rom_mem [4096];
  logic [7:0] r1_a, r2_a, r2_b;
  always @(posedge clk) begin
    r1_a <= rom_mem[rom_ad1];
    r2_a <= rom_mem[rom_ad2];
    r2_b <= r2_a;
  end
  assign rom_data1 = r1_a;
  assign rom_data2 = r2_b;

  // ---------------- write monitor ----------------
  logic        sel = 1'b0;
  logic        ce_m, done_m, busy_m;
  logic [10:0] vad_m;
  logic [7:0]  vdat_m;
  assign ce_m   = sel ? ce2 : ce1;
  assign done_m = sel ? done2 : done1;
  assign busy_m = sel ? busy2 : busy1;
  assign vad_m  = sel ? vad2 : vad1;
  assign vdat_m = sel ? vdat2 : vdat1;

  int         w_cyc_q[$];
  logic [10:0] w_ad_q[$];
  logic [7:0]  w_dat_q[$];
  int         d_cyc_q[$];
  int         busy_cnt;

  always @(negedge clk) begin
    if (ce_m) begin
      w_cyc_q.push_back(cyc);
      w_ad_q.push_back(vad_m);
      w_dat_q.push_back(vdat_m);
    end
    if (done_m) d_cyc_q.push_back(cyc);
    if (busy_m) busy_cnt++;
  end

  // ---------------- scoreboard / reference model ----------------
  int          total = 0;
  int          bad = 0;
  bit          allow_pat[$];   // allow value for cycle start+1+r
  int          exp_cyc_q[$];
  logic [10:0] exp_ad_q[$];
  logic [7:0]  exp_dat_q[$];
  int          exp_done;
  int          exp_busy;

  // The n-th byte is issued in the n-th allowed cycle after start and is
  // written lat cycles later; done follows the last write by one cycle.
  task automatic build_exp(input logic m, input logic [7:0] fv, input logic [11:0] sb,
                           input logic [10:0] db, input int len, input int t0, input int lat);
    int r;
    logic [10:0] a;
    logic [11:0] ra;
    exp_cyc_q.delete();
    exp_ad_q.delete();
    exp_dat_q.delete();
    r = 0;
    for (int n = 0; n < len; n++) begin
      while (r < allow_pat.size() && allow_pat[r] == 1'b0) r++;
      a  = db + 11'(n);
      ra = sb + 12'(n);
      exp_cyc_q.push_back(t0 + 1 + r + lat);
      exp_ad_q.push_back(a);
      exp_dat_q.push_back(m ? fv : rom_mem[ra]);
      r++;
    end
    if (len == 0) exp_done = t0 + 1;
    else          exp_done = exp_cyc_q[exp_cyc_q.size()-1] + 1;
    exp_busy = exp_done - t0;
  endtask

  // ---------------- driver ----------------
  // Pulses start with the given request, scrambles the request inputs
  // afterwards, plays allow_pat, optionally re-pulses start at restart_rel.
  task automatic drive_xfer(input logic m, input logic [7:0] fv, input logic [11:0] sb,
                            input logic [10:0] db, input logic [11:0] len,
                            input int restart_rel, output int t0);
    bit timed_out;
    int budget;
    w_cyc_q.delete(); w_ad_q.delete(); w_dat_q.delete(); d_cyc_q.delete();
    busy_cnt = 0;
    budget = int'(len) + allow_pat.size() + 30;
    @(posedge clk); #1;
    start = 1'b1; mode = m; fill_value = fv; src_base = sb; dst_base = db; length = len;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom); fill_value = 8'($urandom); src_base = 12'($urandom);
    dst_base = 11'($urandom); length = 12'($urandom_range(1, 9));
    timed_out = 1'b1;
    for (int r = 0; r < budget; r++) begin
      allow = (r < allow_pat.size()) ? allow_pat[r] : 1'b1;
      start = (r == restart_rel);
      if (r == restart_rel) begin
        src_base = 12'($urandom); dst_base = 11'($urandom);
        length = 12'($urandom_range(1, 9)); mode = 1'($urandom);
      end
      @(posedge clk); #1;
      if (d_cyc_q.size() != 0 && cyc >= d_cyc_q[0] + 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    allow = 1'b1;
    if (timed_out) begin
      total++; bad++;
      $display("FAIL xfer_timeout: got no done within %0d cycles, want done", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (st1 !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", st1, IDLE); end
    total++; if ({busy1, done1, ce1} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy1, done1, ce1}); end
    total++; if (rom_ad1 !== 12'h000) begin bad++; $display("FAIL rst_rom_ad: got %h want 000", rom_ad1); end
    total++; if ({vad1, vdat1} !== 19'h0) begin bad++; $display("FAIL rst_vram: got %h/%h want 000/00", vad1, vdat1); end
    total++; if ({busy2, done2, ce2} !== 3'b000) begin bad++; $display("FAIL rst_flags2: got %b want 000", {busy2, done2, ce2}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (st1 !== IDLE || busy1 !== 1'b0) begin bad++; $display("FAIL rst_release: got st=%0d busy=%b want IDLE/0", st1, busy1); end
  endtask

  task automatic test_copy_basic();
    int t0;
    sel = 1'b0;
    allow_pat.delete();
    rom_mem[12'h010] = 8'hA1; rom_mem[12'h011] = 8'hB2;
    rom_mem[12'h012] = 8'hC3; rom_mem[12'h013] = 8'hD4;
    drive_xfer(MODE_COPY, 8'h00, 12'h010, 11'h000, 12'd4, -1, t0);
    build_exp(MODE_COPY, 8'h00, 12'h010, 11'h000, 4, t0, 1);
    total++; if (w_ad_q.size() !== 4) begin bad++; $display("FAIL copy_count: got %0d want 4", w_ad_q.size()); end
    for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
      total++;
      if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== exp_dat_q[i]) begin
        bad++; $display("FAIL copy_wr%0d: got c%0d %h=%h want c%0d %h=%h", i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i], exp_dat_q[i]);
      end
    end
    total++; if (w_cyc_q.size() == 0 || w_cyc_q[0] - t0 !== 2) begin bad++; $display("FAIL copy_latency: got %0d want 2", w_cyc_q.size() ? w_cyc_q[0] - t0 : -1); end
    total++; if (w_dat_q.size() < 4 || w_dat_q[3] !== 8'hD4) begin bad++; $display("FAIL copy_last_data: got %h want d4", w_dat_q.size() >= 4 ? w_dat_q[3] : 8'hxx); end
    total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== exp_done) begin bad++; $display("FAIL copy_done: got n=%0d c=%0d want n=1 c=%0d", d_cyc_q.size(), d_cyc_q.size() ? d_cyc_q[0] : -1, exp_done); end
    total++; if (busy_cnt !== exp_busy) begin bad++; $display("FAIL copy_busy: got %0d want %0d", busy_cnt, exp_busy); end
  endtask

  task automatic test_fill_wrap();
    int t0;
    sel = 1'b0;
    allow_pat.delete();
    drive_xfer(MODE_FILL, 8'h55, 12'($urandom), 11'h7FE, 12'd4, -1, t0);
    build_exp(MODE_FILL, 8'h55, 12'h000, 11'h7FE, 4, t0, 1);
    total++; if (w_ad_q.size() !== 4) begin bad++; $display("FAIL fill_count: got %0d want 4", w_ad_q.size()); end
    for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
      total++;
      if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== 8'h55) begin
        bad++; $display("FAIL fill_wr%0d: got c%0d %h=%h want c%0d %h=55", i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i]);
      end
    end
    total++; if (w_ad_q.size() < 3 || w_ad_q[2] !== 11'h000) begin bad++; $display("FAIL fill_wrap: got %h want 000", w_ad_q.size() >= 3 ? w_ad_q[2] : 11'hx); end
    total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== exp_done) begin bad++; $display("FAIL fill_done: got n=%0d want n=1 c=%0d", d_cyc_q.size(), exp_done); end
  endtask

  task automatic test_allow_gap();
    int t0;
    logic [11:0] sb;
    logic [10:0] db;
    sel = 1'b0;
    sb = 12'($urandom); db = 11'($urandom);
    allow_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    drive_xfer(MODE_COPY, 8'h00, sb, db, 12'd6, -1, t0);
    build_exp(MODE_COPY, 8'h00, sb, db, 6, t0, 1);
    total++; if (w_ad_q.size() !== 6) begin bad++; $display("FAIL gap_count: got %0d want 6", w_ad_q.size()); end
    for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
      total++;
      if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== exp_dat_q[i]) begin
        bad++; $display("FAIL gap_wr%0d: got c%0d %h=%h want c%0d %h=%h", i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i], exp_dat_q[i]);
      end
    end
    total++; if (w_cyc_q.size() < 3 || w_cyc_q[2] - w_cyc_q[1] !== 4) begin bad++; $display("FAIL gap_len: got %0d want 4", w_cyc_q.size() >= 3 ? w_cyc_q[2] - w_cyc_q[1] : -1); end
    total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== exp_done) begin bad++; $display("FAIL gap_done: got n=%0d want n=1 c=%0d", d_cyc_q.size(), exp_done); end
    allow_pat.delete();
  endtask

  task automatic test_zero_len();
    int t0;
    sel = 1'b0;
    allow_pat.delete();
    drive_xfer(MODE_COPY, 8'h00, 12'($urandom), 11'($urandom), 12'd0, -1, t0);
    total++; if (w_ad_q.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", w_ad_q.size()); end
    total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== t0 + 1) begin bad++; $display("FAIL zero_done: got n=%0d c=%0d want n=1 c=%0d", d_cyc_q.size(), d_cyc_q.size() ? d_cyc_q[0] : -1, t0 + 1); end
    total++; if (busy_cnt !== 1) begin bad++; $display("FAIL zero_busy: got %0d want 1", busy_cnt); end
  endtask

  task automatic test_restart_ignored();
    int t0;
    logic [11:0] sb;
    logic [10:0] db;
    sel = 1'b0;
    allow_pat.delete();
    sb = 12'($urandom); db = 11'($urandom);
    drive_xfer(MODE_COPY, 8'h00, sb, db, 12'd6, 2, t0);
    build_exp(MODE_COPY, 8'h00, sb, db, 6, t0, 1);
    total++; if (w_ad_q.size() !== 6) begin bad++; $display("FAIL restart_count: got %0d want 6", w_ad_q.size()); end
    for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
      total++;
      if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== exp_dat_q[i]) begin
        bad++; $display("FAIL restart_wr%0d: got c%0d %h=%h want c%0d %h=%h", i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i], exp_dat_q[i]);
      end
    end
    total++; if (d_cyc_q.size() !== 1) begin bad++; $display("FAIL restart_done: got %0d pulses want 1", d_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    int t0;
    sel = 1'b0;
    w_cyc_q.delete(); w_ad_q.delete(); w_dat_q.delete(); d_cyc_q.delete();
    @(posedge clk); #1;
    start = 1'b1; mode = MODE_COPY; src_base = 12'($urandom); dst_base = 11'($urandom); length = 12'd8;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // writes land in t0+2 and t0+3; the third would be in t0+4
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if ({ce1, busy1, done1} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got ce/busy/done=%b want 000", {ce1, busy1, done1}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (st1 !== IDLE || busy1 !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got st=%0d busy=%b want IDLE/0", st1, busy1); end
    total++; if (w_ad_q.size() !== 2) begin bad++; $display("FAIL rstmid_writes: got %0d want 2", w_ad_q.size()); end
    total++; if (d_cyc_q.size() !== 0) begin bad++; $display("FAIL rstmid_done: got %0d pulses want 0", d_cyc_q.size()); end
  endtask

  task automatic test_lat2();
    int t0;
    sel = 1'b1;
    allow_pat.delete();
    drive_xfer(MODE_COPY, 8'h00, 12'h010, 11'h000, 12'd4, -1, t0);
    build_exp(MODE_COPY, 8'h00, 12'h010, 11'h000, 4, t0, 2);
    total++; if (w_ad_q.size() !== 4) begin bad++; $display("FAIL lat2_count: got %0d want 4", w_ad_q.size()); end
    for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
      total++;
      if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== exp_dat_q[i]) begin
        bad++; $display("FAIL lat2_wr%0d: got c%0d %h=%h want c%0d %h=%h", i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i], exp_dat_q[i]);
      end
    end
    total++; if (w_cyc_q.size() == 0 || w_cyc_q[0] - t0 !== 3) begin bad++; $display("FAIL lat2_latency: got %0d want 3", w_cyc_q.size() ? w_cyc_q[0] - t0 : -1); end
    total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== exp_done) begin bad++; $display("FAIL lat2_done: got n=%0d want n=1 c=%0d", d_cyc_q.size(), exp_done); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int t0;
    int lat;
    logic m;
    logic [7:0] fv;
    logic [11:0] sb, len;
    logic [10:0] db;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom);
      lat = sel ? 2 : 1;
      m = 1'($urandom); fv = 8'($urandom); sb = 12'($urandom); db = 11'($urandom);
      len = (it == 3) ? 12'd2060 : 12'($urandom_range(0, 40));
      allow_pat.delete();
      for (int r = 0; r < $urandom_range(0, 60); r++) allow_pat.push_back($urandom_range(0, 3) != 0);
      drive_xfer(m, fv, sb, db, len, -1, t0);
      build_exp(m, fv, sb, db, int'(len), t0, lat);
      total++; if (w_ad_q.size() !== exp_ad_q.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, w_ad_q.size(), exp_ad_q.size()); end
      for (int i = 0; i < exp_ad_q.size() && i < w_ad_q.size(); i++) begin
        total++;
        if (w_cyc_q[i] !== exp_cyc_q[i] || w_ad_q[i] !== exp_ad_q[i] || w_dat_q[i] !== exp_dat_q[i]) begin
          bad++; $display("FAIL rnd%0d_wr%0d: got c%0d %h=%h want c%0d %h=%h", it, i, w_cyc_q[i], w_ad_q[i], w_dat_q[i], exp_cyc_q[i], exp_ad_q[i], exp_dat_q[i]);
        end
      end
      total++; if (d_cyc_q.size() !== 1 || d_cyc_q[0] !== exp_done) begin bad++; $display("FAIL rnd%0d_done: got n=%0d want n=1 c=%0d", it, d_cyc_q.size(), exp_done); end
      total++; if (busy_cnt !== exp_busy) begin bad++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, busy_cnt, exp_busy); end
    end
    sel = 1'b0;
    allow_pat.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    test_reset();
    test_copy_basic();
    test_fill_wrap();
    test_allow_gap();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    test_lat2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
